// File: rtl/app_pkg.sv
// Shared types and sizing helpers for the adder arbiter slice.
// Operand/result widths match the 4-bit addr adder instance.
package app_pkg;

  localparam int A_W = 4;
  localparam int C_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first valid requester at or after ptr, wrapping.
// Purely combinational; grant is one-hot or zero, idx is meaningful only with any_valid.
module rr_arbiter
  import app_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any_valid
);

  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % N_REQ);
  endfunction

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_valid && req_valid[wrap(int'(ptr) + i)]) begin
        any_valid = 1'b1;
        idx       = wrap(int'(ptr) + i);
      end
    end
    grant[idx] = any_valid;
  end

endmodule

// File: rtl/addr_arbiter.sv
// Round-robin sharing of one adder among N_REQ requesters; accept-to-response is 2+ADD_LAT cycles.
// One operation in flight; requesters wait (ready low) until the response has been taken.
module addr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int A_W     = app_pkg::A_W,
  parameter int C_W     = A_W + 1,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = app_pkg::id_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [N_REQ*A_W-1:0] req_a_i,
  input  logic [N_REQ*A_W-1:0] req_b_i,
  output logic [A_W-1:0]       add_a_o,
  output logic [A_W-1:0]       add_b_o,
  input  logic [C_W-1:0]       add_c_i,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [C_W-1:0]       rsp_c_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o
);

  import app_pkg::*;

  localparam int CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, id_q, grant_idx;
  logic [N_REQ-1:0] grant;
  logic             any_valid;
  logic             accept, capture;
  logic [A_W-1:0]   a_q, b_q;
  logic [C_W-1:0]   c_q;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    return (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req_valid(req_valid_i),
    .ptr      (ptr_q),
    .grant    (grant),
    .idx      (grant_idx),
    .any_valid(any_valid)
  );

  // Grant is only offered from IDLE, so at most one operation is ever in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    capture     = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst && any_valid) begin
          req_ready_o = grant;
          accept      = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(ADD_LAT)) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands stay on the adder inputs until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      ptr_q <= '0;
      c_q   <= '0;
    end else begin
      if (accept) begin
        a_q   <= req_a_i[int'(grant_idx)*A_W +: A_W];
        b_q   <= req_b_i[int'(grant_idx)*A_W +: A_W];
        id_q  <= grant_idx;
        ptr_q <= next_ptr(grant_idx);
      end
      if (capture) c_q <= add_c_i;
    end
  end

  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_c_o     = c_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/addr_arbiter.md
Name: addr_arbiter

Overview:
- Shares the single 4-bit `addr` adder (operands a/b, 5-bit sum c) among N_REQ on-chip requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and picks one requester at a time in round-robin order.
- Sequences the adder by holding operands for its fixed latency, then returns the 5-bit sum tagged with the requester ID.
- Sits between requester logic and the `addr` instance inside APP.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- A_W, 4, operand width.
- C_W, A_W+1, result width.
- ADD_LAT, 1, adder latency in cycles from operands stable to sum valid (0 = combinational).
- ID_W, max(1,$clog2(N_REQ)), requester ID width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester operand valid.
- req_ready_o  out  N_REQ  per-requester accept strobe, one-hot or zero.
- req_a_i  in  N_REQ*A_W  operand a, requester k at bits [k*A_W +: A_W].
- req_b_i  in  N_REQ*A_W  operand b, same packing.
- add_a_o  out  A_W  to adder a_i.
- add_b_o  out  A_W  to adder b_i.
- add_c_i  in  C_W  from adder c_o.
- rsp_valid_o  out  1  result valid.
- rsp_id_o  out  ID_W  index of the requester that owns the result.
- rsp_c_o  out  C_W  sum.
- rsp_ready_i  in  1  result consumer ready.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release) puts every output at 0:
  - req_ready_o, add_a_o, add_b_o, rsp_valid_o, rsp_id_o, rsp_c_o and busy_o all 0.
  - Round-robin pointer ptr=0, state IDLE, latency counter 0.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - The winner g is the first k with req_valid_i[k]=1, searching k = ptr, ptr+1, … mod N_REQ.
  - req_ready_o[g] is asserted combinationally in the same cycle T. Handshake = valid & ready.
  - At edge T: capture a/b of g into add_a_o/add_b_o registers, capture g into the ID register, set ptr = (g+1) mod N_REQ, cnt=0, go to WAIT.
  - If no request is valid, stay in IDLE; ptr is unchanged.
- WAIT:
  - req_ready_o=0.
  - If cnt==ADD_LAT: capture add_c_i into rsp_c_o and go to RESP. Otherwise cnt++.
  - Capture happens in cycle T+1+ADD_LAT; rsp_valid_o first asserts in cycle T+2+ADD_LAT (T+3 at default).
- RESP:
  - rsp_valid_o=1; rsp_id_o and rsp_c_o are stable while rsp_valid_o & !rsp_ready_i.
  - On rsp_ready_i=1: go to IDLE, drop rsp_valid_o next cycle.
  - No new request is accepted in the handshake cycle itself.
  - Minimum issue period is 3+ADD_LAT cycles.
- add_a_o/add_b_o hold the last operands between operations; they change only at accept.
- Arithmetic: the sum is whatever the adder returns, with no truncation. 15+15 = 5'd30 is full range.
- Simultaneous requests: exactly one is granted; the others keep valid asserted and are served in rotation. No starvation; worst-case wait is N_REQ-1 operations.
- A requester that drops valid before being granted is simply skipped. Requesters must hold a/b stable while valid & !ready.
- N_REQ=1: ptr is constant 0, rsp_id_o=0.
- rsp_ready_i held high: the response lasts exactly one cycle.
- rst mid-operation (WAIT or RESP): the operation is discarded and no response is emitted. All outputs return to their reset values immediately, since reset is asynchronous.
- rsp_ready_i and all req_* are ignored while rst=1.

Decomposition:
- Shared package app_pkg holds:
  - A_W=4, C_W=5;
  - arb_state_t enum {IDLE, WAIT, RESP};
  - function id_width(n).
- One sub-module, rr_arbiter: combinational rotating-priority pick over req_valid_i given ptr. Outputs a one-hot grant, the index g and an any_valid flag.

Test Plan:
- Single request: requester 2 sends a=4'd9, b=4'd7 at cycle 0 with rsp_ready_i=1. Required: req_ready_o=4'b0100 at cycle 0; add_a_o/add_b_o = 9/7 from cycle 1; rsp_valid_o for exactly one cycle at cycle 3 with rsp_id_o=2, rsp_c_o=5'd16.
- All four requesters valid continuously with a=k, b=15, rsp_ready_i=1. Required: grants in order 0,1,2,3,0; results 15,16,17,18,15; consecutive accepts 4 cycles apart.
- Backpressure: rsp_ready_i=0 for 5 cycles after the result for a=15, b=15. Required: rsp_valid_o=1, rsp_c_o=5'd30 and rsp_id_o held stable throughout; no req_ready_o during that time; IDLE one cycle after rsp_ready_i rises.
- Rotation fairness: after requester 3 is served, requesters 0 and 3 both become valid. Required: 0 is granted first (ptr=0), then 3.
- Reset mid-WAIT: assert rst one cycle after the accept. Required: all outputs are 0 within the same cycle; after release no rsp_valid_o appears; ptr=0, so requester 0 wins the next contention.
- ADD_LAT=0 instance with a combinational adder model, a=4'd1, b=4'd2. Required: rsp_valid_o at cycle T+2 with rsp_c_o=5'd3.
